seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Time-multiplexed driver for a 4-digit common-anode seven-segment display. It replaces externally driven digit-select with a free-running refresh scanner and generates the one-hot active-low anode enables. It holds a tear-free shadow copy of the four hex digits and decodes the selected digit to active-low segments. It sits between the datapath (which loads display values) and the board's `seg`/`an` pins.

## Interface
- `REFRESH_DIV`, 100000 — clock cycles per digit slot; must be ≥ 2.
- `BLANK_CYC`, 16 — inter-digit blanking length in cycles; used only with `SEG7_BLANK_EN`; must be < `REFRESH_DIV`.
- `clk`  in  1  — single system clock.
- `rst_n`  in  1  — synchronous, active-low reset.
- `en`  in  1  — scan enable; 0 holds the counters and forces all anodes off.
- `load`  in  1  — one-cycle strobe that captures `data`.
- `data`  in  16  — digits: d3=[15:12], d2=[11:8], d1=[7:4], d0=[3:0].
- `seg`  out  7  — active-low segments {g,f,e,d,c,b,a}.
- `an`  out  4  — active-low anodes; `an[k]` lights digit k.
- `digit_sel`  out  2  — index of the digit currently being scanned.
- `frame_done`  out  1  — one-cycle pulse when the 3→0 wrap occurs.

## Operation
- Slot counter `tick_cnt` counts 0..REFRESH_DIV-1 while `en`=1. At terminal count it wraps to 0 and `digit_sel` increments modulo 4.
- Pending register: `load`=1 writes `data` into `pending` and sets `pend_vld`. A second `load` before the frame boundary overwrites it (last write wins).
- Frame boundary is the cycle where `tick_cnt`=REFRESH_DIV-1 and `digit_sel`=3 with `en`=1. At the boundary, if `pend_vld` is set, `shadow`←`pending` and `pend_vld` clears.
- `load` in the boundary cycle writes `data` straight to `shadow` and leaves `pend_vld` clear.
- Display changes therefore happen only at a frame start.
- Registered outputs:
  - `an` = ~(1<<`digit_sel`).
  - `seg` = decode(`shadow` nibble[`digit_sel`]).
- Decode values (hex, active-low):
  - 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000
  - 8→0000000, 9→0010000, A→0001000, b→0000011, C→1000110, d→0100001, E→0000110, F→0001110
- `en`=0: `tick_cnt` and `digit_sel` hold; `an`=1111 and `seg`=1111111 from the next cycle; `load` is still accepted into `pending`; no boundary occurs.

## Timing
- Reset values (synchronous, `rst_n`=0 at a rising edge):
  - `tick_cnt`=0, `digit_sel`=0, `an`=1111, `seg`=1111111, `frame_done`=0.
  - `shadow`=0, `pending`=0, `pend_vld`=0.
- First edge after reset release with `en`=1: `an`=1110, `seg`=1000000.
- Output latency: one cycle from the `digit_sel`/`shadow` change to `an`/`seg`.
- Each digit is lit for exactly REFRESH_DIV cycles; a full frame is 4·REFRESH_DIV cycles.
- `frame_done` is asserted on the edge that wraps `digit_sel` 3→0. The new `shadow` is visible on `seg` one cycle later.
- Reset mid-frame discards `pending`, returns to digit 0 and blanks outputs for one cycle.

## Configuration
- `SEG7_BLANK_EN` defined:
  - `an`=1111 during the last BLANK_CYC cycles of every slot (`tick_cnt` ≥ REFRESH_DIV-BLANK_CYC) to suppress ghosting.
  - `seg` still tracks the current digit during blanking.
- Undefined: no blanking; the anode stays on for the full slot. `BLANK_CYC` is ignored.

## Structure
- Package `seg7_pkg`:
  - `SEG_BLANK` = 7'b1111111.
  - `AN_OFF` = 4'b1111.
  - 16-entry hex-to-segment constant table.
  - `digit_t` (4-bit) typedef.
- Sub-module `seg7_decode`: combinational 4-bit→7-bit active-low decoder, instantiated once on the selected nibble.
- Scanner counters, shadow/pending logic and output registers live in `seg7_scan_driver`.

## Test plan
- Use REFRESH_DIV=4, BLANK_CYC=1 for all scenarios.
- Reset then `en`=1, shadow 0 → `an` steps 1110,1101,1011,0111 every 4 cycles, `seg`=1000000 throughout. `frame_done` pulses every 16 cycles.
- `load` `data`=16'hF3A1 mid-frame → old digits are shown until `frame_done`, then digit0..3 show 1111001, 0001000, 0110000, 0001110.
- Two `load`s (16'h1111, then 16'h2222) in one frame → the next frame shows only 2 (0100100) on all digits.
- `load` in the boundary cycle with 16'h0008 → digit0 shows 0000000 in the immediately following frame.
- `en`=0 for 10 cycles mid-slot → `an`=1111, `seg`=1111111 and the counters frozen. On resume, the remaining slot cycles complete on the same digit.
- With `SEG7_BLANK_EN`: the last cycle of each slot has `an`=1111. Without it: the anode is never all-off while `en`=1. Assert `rst_n`=0 mid-frame with `pend_vld` set → pending is lost and the display stays 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan driver.
package seg7_pkg;

  typedef logic [3:0] digit_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Active-low {g,f,e,d,c,b,a}, indexed by hex digit value.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Datapath-facing bundle of the scan driver: load/enable controls and display pins.
interface seg7_scan_driver_if;

  logic        en;
  logic        load;
  logic [15:0] data;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [1:0]  digit_sel;
  logic        frame_done;

  modport master (
    output en, load, data,
    input  seg, an, digit_sel, frame_done
  );

  modport slave (
    input  en, load, data,
    output seg, an, digit_sel, frame_done
  );

endinterface

// File: rtl/seg7_decode.sv
// Combinational hex digit to active-low seven-segment decoder.
module seg7_decode
  import seg7_pkg::*;
(
  input  digit_t     digit,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[digit];

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver with tear-free frame-aligned updates.
// Optional inter-digit anode blanking is enabled by defining SEG7_BLANK_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_CYC   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  seg7_scan_driver_if.slave bus
);

  localparam int unsigned CntW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BlankStart = REFRESH_DIV - BLANK_CYC;
`ifdef SEG7_BLANK_EN
  localparam bit BlankEn = 1'b1;
`else
  localparam bit BlankEn = 1'b0;
`endif

  logic [CntW-1:0] tick_cnt_q, tick_cnt_d;
  logic [1:0]      digit_sel_q, digit_sel_d;
  logic [15:0]     shadow_q, shadow_d;
  logic [15:0]     pending_q, pending_d;
  logic            pend_vld_q, pend_vld_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            frame_done_q;

  logic            slot_end;
  logic            boundary;
  logic            in_blank;
  digit_t          cur_digit;
  logic [6:0]      dec_seg;

  assign slot_end = (tick_cnt_q == CntW'(REFRESH_DIV - 1));
  assign boundary = bus.en && slot_end && (digit_sel_q == 2'd3);
  // Compared at 32 bits so BLANK_CYC = 0 never aliases to a truncated start.
  assign in_blank = BlankEn && (32'(tick_cnt_q) >= BlankStart);

  assign cur_digit = shadow_q[{digit_sel_q, 2'b00} +: 4];

  seg7_decode u_decode (
    .digit (cur_digit),
    .seg   (dec_seg)
  );

  always_comb begin
    tick_cnt_d  = tick_cnt_q;
    digit_sel_d = digit_sel_q;
    if (bus.en) begin
      if (slot_end) begin
        tick_cnt_d  = '0;
        digit_sel_d = digit_sel_q + 2'd1;
      end else begin
        tick_cnt_d = tick_cnt_q + 1'b1;
      end
    end
  end

  // Display contents only change at a frame boundary; loads elsewhere are parked.
  always_comb begin
    shadow_d   = shadow_q;
    pending_d  = pending_q;
    pend_vld_d = pend_vld_q;
    if (boundary) begin
      pend_vld_d = 1'b0;
      if (bus.load) begin
        shadow_d = bus.data;
      end else if (pend_vld_q) begin
        shadow_d = pending_q;
      end
    end else if (bus.load) begin
      pending_d  = bus.data;
      pend_vld_d = 1'b1;
    end
  end

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    if (bus.en) begin
      seg_d = dec_seg;
      if (!in_blank) begin
        an_d = ~(4'b0001 << digit_sel_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt_q   <= '0;
      digit_sel_q  <= 2'd0;
      shadow_q     <= '0;
      pending_q    <= '0;
      pend_vld_q   <= 1'b0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_BLANK;
      frame_done_q <= 1'b0;
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      digit_sel_q  <= digit_sel_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      pend_vld_q   <= pend_vld_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= boundary;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.digit_sel  = digit_sel_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed scenarios plus a per-cycle reference model.
module tb_seg7_scan_driver;

  localparam int RD = 4;
  localparam int BC = 1;
`ifdef SEG7_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  localparam logic [6:0] TBL [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic clk;
  logic rst_n;
  seg7_scan_driver_if bus ();

  seg7_scan_driver #(
    .REFRESH_DIV (RD),
    .BLANK_CYC   (BC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model state: pos counts enabled cycles since reset; the scan position follows from it.
  int          pos      = 0;
  logic [15:0] m_shadow = '0;
  logic [15:0] m_pend   = '0;
  bit          m_pv     = 1'b0;
  logic [3:0]  exp_an   = 4'hF;
  logic [6:0]  exp_seg  = 7'h7F;
  logic        exp_fd   = 1'b0;
  logic [1:0]  exp_dsel = 2'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  initial begin
    int dig;
    logic [3:0] nib;
    bit bnd;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        pos = 0; m_shadow = '0; m_pend = '0; m_pv = 1'b0;
        exp_an = 4'hF; exp_seg = 7'h7F; exp_fd = 1'b0; exp_dsel = 2'd0;
      end else begin
        dig = (pos / RD) % 4;
        nib = 4'((m_shadow >> (4 * dig)) & 16'hF);
        exp_seg = bus.en ? TBL[nib] : 7'h7F;
        exp_an = 4'hF;
        if (bus.en && !(BLANK && (pos % RD) >= RD - BC)) exp_an[dig] = 1'b0;
        bnd = bus.en && (pos % (4 * RD) == 4 * RD - 1);
        exp_fd = bnd;
        if (bnd) begin
          if (bus.load) m_shadow = bus.data;
          else if (m_pv) m_shadow = m_pend;
          m_pv = 1'b0;
        end else if (bus.load) begin
          m_pend = bus.data;
          m_pv = 1'b1;
        end
        if (bus.en) pos++;
        exp_dsel = 2'((pos / RD) % 4);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("an", {12'b0, bus.an}, {12'b0, exp_an});
      chk("seg", {9'b0, bus.seg}, {9'b0, exp_seg});
      chk("frame_done", {15'b0, bus.frame_done}, {15'b0, exp_fd});
      chk("digit_sel", {14'b0, bus.digit_sel}, {14'b0, exp_dsel});
    end
  end

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load(logic [15:0] d);
    bus.load = 1'b1;
    bus.data = d;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic wait_fd(string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.frame_done !== 1'b1 && n < 40);
    chk(nm, {15'b0, bus.frame_done}, 16'd1);
  endtask

  initial begin
    int fd_cnt;
    rst_n    = 1'b0;
    bus.en   = 1'b0;
    bus.load = 1'b0;
    bus.data = '0;
    step(2);
    chk("rst_an", {12'b0, bus.an}, 16'h000F);
    chk("rst_seg", {9'b0, bus.seg}, 16'h007F);
    chk("rst_fd", {15'b0, bus.frame_done}, 16'd0);

    // Basic scan from reset with shadow 0
    rst_n  = 1'b1;
    bus.en = 1'b1;
    step(1);
    chk("first_an", {12'b0, bus.an}, 16'b1110);
    chk("first_seg", {9'b0, bus.seg}, 16'b1000000);
    step(4);
    chk("digit1_an", {12'b0, bus.an}, 16'b1101);
    fd_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) fd_cnt++;
    end
    chk("fd_per_32", 16'(fd_cnt), 16'd2);

    // Mid-frame load appears only after the frame boundary
    pulse_load(16'hF3A1);
    chk("old_digits", {9'b0, bus.seg}, 16'b1000000);
    wait_fd("fd_after_f3a1");
    step(1);
    chk("f3a1_d0", {9'b0, bus.seg}, 16'b1111001);
    step(4);
    chk("f3a1_d1", {9'b0, bus.seg}, 16'b0001000);
    step(4);
    chk("f3a1_d2", {9'b0, bus.seg}, 16'b0110000);
    step(4);
    chk("f3a1_d3", {9'b0, bus.seg}, 16'b0001110);

    // Last of two loads in a frame wins
    wait_fd("fd_before_double");
    pulse_load(16'h1111);
    pulse_load(16'h2222);
    wait_fd("fd_after_double");
    step(1);
    chk("double_d0", {9'b0, bus.seg}, 16'b0100100);
    step(12);
    chk("double_d3", {9'b0, bus.seg}, 16'b0100100);

    // Load on the boundary cycle goes straight to the next frame
    wait_fd("fd_before_bnd");
    step(15);
    pulse_load(16'h0008);
    chk("bnd_fd", {15'b0, bus.frame_done}, 16'd1);
    step(1);
    chk("bnd_d0", {9'b0, bus.seg}, 16'b0000000);
    step(4);
    chk("bnd_d1", {9'b0, bus.seg}, 16'b1000000);

    // Scan disable mid-slot, with a load accepted while disabled
    bus.en = 1'b0;
    step(1);
    chk("dis_an", {12'b0, bus.an}, 16'h000F);
    chk("dis_seg", {9'b0, bus.seg}, 16'h007F);
    chk("dis_dsel", {14'b0, bus.digit_sel}, 16'd1);
    pulse_load(16'h0005);
    step(8);
    chk("dis_hold_dsel", {14'b0, bus.digit_sel}, 16'd1);
    bus.en = 1'b1;
    step(1);
    chk("resume_an", {12'b0, bus.an}, 16'b1101);
    wait_fd("fd_after_resume");
    step(1);
    chk("resume_d0", {9'b0, bus.seg}, 16'b0010010);

    // Mid-frame reset drops a pending load
    pulse_load(16'h0009);
    step(3);
    rst_n = 1'b0;
    step(1);
    chk("mid_rst_an", {12'b0, bus.an}, 16'h000F);
    chk("mid_rst_seg", {9'b0, bus.seg}, 16'h007F);
    chk("mid_rst_dsel", {14'b0, bus.digit_sel}, 16'd0);
    rst_n = 1'b1;
    step(1);
    chk("post_rst_an", {12'b0, bus.an}, 16'b1110);
    wait_fd("fd_after_rst");
    step(1);
    chk("post_rst_d0", {9'b0, bus.seg}, 16'b1000000);
    step(12);
    chk("post_rst_d3", {9'b0, bus.seg}, 16'b1000000);

    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
